// File: rtl/decode_stage_pkg.sv
// Shared RISC-V encoding constants and types for the decode stage.
package decode_stage_pkg;

  // Major opcodes
  localparam logic [6:0] RISCV_LOAD      = 7'b0000011;
  localparam logic [6:0] RISCV_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] RISCV_OP_IMM    = 7'b0010011;
  localparam logic [6:0] RISCV_AUIPC     = 7'b0010111;
  localparam logic [6:0] RISCV_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] RISCV_STORE     = 7'b0100011;
  localparam logic [6:0] RISCV_OP        = 7'b0110011;
  localparam logic [6:0] RISCV_LUI       = 7'b0110111;
  localparam logic [6:0] RISCV_OP_32     = 7'b0111011;
  localparam logic [6:0] RISCV_BRANCH    = 7'b1100011;
  localparam logic [6:0] RISCV_JALR      = 7'b1100111;
  localparam logic [6:0] RISCV_JAL       = 7'b1101111;
  localparam logic [6:0] RISCV_SYSTEM    = 7'b1110011;

  // Load widths
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LD  = 3'b011;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
  localparam logic [2:0] LOAD_LWU = 3'b110;

  // Store widths
  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;
  localparam logic [2:0] STORE_SD = 3'b011;

  // Branch conditions
  localparam logic [2:0] BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] BRANCH_BNE  = 3'b001;
  localparam logic [2:0] BRANCH_BLT  = 3'b100;
  localparam logic [2:0] BRANCH_BGE  = 3'b101;
  localparam logic [2:0] BRANCH_BLTU = 3'b110;
  localparam logic [2:0] BRANCH_BGEU = 3'b111;

  // ALU func3 / func7 codes
  localparam logic [2:0] FUNC3_ADD    = 3'b000;
  localparam logic [2:0] FUNC3_SLL    = 3'b001;
  localparam logic [2:0] FUNC3_SRL    = 3'b101;
  localparam logic [6:0] FUNC7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } dec_fields_t;

  // Register-register legality; word_op selects the OP-32 subset.
  function automatic logic reg_op_legal(input logic [2:0] func3, input logic [6:0] func7,
                                        input logic m_ok, input logic word_op);
    logic ok;
    case (func7)
      FUNC7_BASE:   ok = word_op ? ((func3 == FUNC3_ADD) || (func3 == FUNC3_SLL) ||
                                    (func3 == FUNC3_SRL)) : 1'b1;
      FUNC7_ALT:    ok = (func3 == FUNC3_ADD) || (func3 == FUNC3_SRL);
      // W mul/div family: mulw, divw, divuw, remw, remuw
      FUNC7_MULDIV: ok = m_ok && (word_op ? ((func3 == 3'b000) || func3[2]) : 1'b1);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_instr_decode.sv
// Combinational RV32I/RV64I decoder: fields, immediate and legality.
module instr_decode
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input  logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam logic IS_RV64 = (XLEN == 64);
  localparam logic M_OK    = (ENABLE_M != 0);

  imm_fmt_e fmt_s;
  logic     bad_enc_s;
  logic     illegal_s;

  assign opcode  = instr[6:0];
  assign func3   = instr[14:12];
  assign func7   = instr[31:25];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign rd      = instr[11:7];
  assign illegal_s = bad_enc_s || (instr[1:0] != 2'b11);
  assign illegal = illegal_s;

  // Classify the opcode: immediate format and encoding legality
  always_comb begin
    fmt_s     = IMM_NONE;
    bad_enc_s = 1'b0;
    case (opcode)
      RISCV_LOAD: begin
        fmt_s = IMM_I;
        case (func3)
          LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU: bad_enc_s = 1'b0;
          LOAD_LD, LOAD_LWU:                             bad_enc_s = !IS_RV64;
          default:                                       bad_enc_s = 1'b1;
        endcase
      end
      RISCV_STORE: begin
        fmt_s = IMM_S;
        case (func3)
          STORE_SB, STORE_SH, STORE_SW: bad_enc_s = 1'b0;
          STORE_SD:                     bad_enc_s = !IS_RV64;
          default:                      bad_enc_s = 1'b1;
        endcase
      end
      RISCV_BRANCH: begin
        fmt_s = IMM_B;
        case (func3)
          BRANCH_BEQ, BRANCH_BNE, BRANCH_BLT,
          BRANCH_BGE, BRANCH_BLTU, BRANCH_BGEU: bad_enc_s = 1'b0;
          default:                              bad_enc_s = 1'b1;
        endcase
      end
      RISCV_JALR: begin
        fmt_s     = IMM_I;
        bad_enc_s = (func3 != 3'b000);
      end
      RISCV_LUI, RISCV_AUIPC: fmt_s = IMM_U;
      RISCV_JAL:              fmt_s = IMM_J;
      RISCV_OP_IMM: begin
        fmt_s = IMM_I;
        // On RV64 instr[25] is shamt[5], so only instr[31:26] qualifies the shift
        case (func3)
          FUNC3_SLL: bad_enc_s = IS_RV64 ? (instr[31:26] != 6'b000000) : (func7 != FUNC7_BASE);
          FUNC3_SRL: bad_enc_s = IS_RV64 ?
                       !((instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000)) :
                       !((func7 == FUNC7_BASE) || (func7 == FUNC7_ALT));
          default:   bad_enc_s = 1'b0;
        endcase
      end
      RISCV_OP_IMM_32: begin
        fmt_s = IMM_I;
        case (func3)
          FUNC3_ADD: bad_enc_s = !IS_RV64;
          FUNC3_SLL: bad_enc_s = !IS_RV64 || (func7 != FUNC7_BASE);
          FUNC3_SRL: bad_enc_s = !IS_RV64 || !((func7 == FUNC7_BASE) || (func7 == FUNC7_ALT));
          default:   bad_enc_s = 1'b1;
        endcase
      end
      RISCV_OP:       bad_enc_s = !reg_op_legal(func3, func7, M_OK, 1'b0);
      RISCV_OP_32:    bad_enc_s = !IS_RV64 || !reg_op_legal(func3, func7, M_OK, 1'b1);
      RISCV_MISC_MEM: bad_enc_s = (func3 != 3'b000);
      RISCV_SYSTEM:   bad_enc_s = (func3 == 3'b100);
      default:        bad_enc_s = 1'b1;
    endcase
  end

  // Assemble the sign-extended immediate; forced to zero for illegal words
  always_comb begin
    imm = {XLEN{1'b0}};
    if (illegal_s) begin
      imm = {XLEN{1'b0}};
    end else begin
      case (fmt_s)
        IMM_I:   imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
        IMM_S:   imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
        IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        IMM_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'h000};
        IMM_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        default: imm = {XLEN{1'b0}};
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a two-entry skid buffer between fetch and execute.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  dec_fields_t     dec_fields_s;
  logic [XLEN-1:0] dec_imm_s;

  skid_state_e     state_r;
  skid_state_e     state_next_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            accept_s;
  logic            drain_s;
  logic            load_out_new_s;
  logic            load_out_skid_s;
  logic            load_skid_s;

  dec_fields_t     out_fields_r;
  logic [XLEN-1:0] out_pc_r;
  logic [XLEN-1:0] out_imm_r;
  dec_fields_t     skid_fields_r;
  logic [XLEN-1:0] skid_pc_r;
  logic [XLEN-1:0] skid_imm_r;

  instr_decode #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_decode (
    .instr   (in_instr),
    .opcode  (dec_fields_s.opcode),
    .func3   (dec_fields_s.func3),
    .func7   (dec_fields_s.func7),
    .rs1     (dec_fields_s.rs1),
    .rs2     (dec_fields_s.rs2),
    .rd      (dec_fields_s.rd),
    .imm     (dec_imm_s),
    .illegal (dec_fields_s.illegal)
  );

  // in_ready comes straight from a flop, so accept never depends on out_ready
  assign accept_s = in_valid && in_ready_r;
  assign drain_s  = out_valid_r && out_ready;

  // Occupancy state register; ready/valid flags registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SKID_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s != SKID_EMPTY);
      in_ready_r  <= (state_next_s != SKID_TWO);
    end
  end

  // Next occupancy from the handshakes; flush overrides everything
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = SKID_EMPTY;
    end else begin
      case (state_r)
        SKID_EMPTY: state_next_s = accept_s ? SKID_ONE : SKID_EMPTY;
        SKID_ONE: begin
          if (accept_s && !drain_s) begin
            state_next_s = SKID_TWO;
          end else if (!accept_s && drain_s) begin
            state_next_s = SKID_EMPTY;
          end else begin
            state_next_s = SKID_ONE;
          end
        end
        SKID_TWO:   state_next_s = drain_s ? SKID_ONE : SKID_TWO;
        default:    state_next_s = SKID_EMPTY;
      endcase
    end
  end

  // Steer the data-register loads for this cycle's transfers
  always_comb begin
    load_out_new_s  = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    if (flush) begin
      load_out_new_s  = 1'b0;
    end else begin
      case (state_r)
        SKID_EMPTY: load_out_new_s = accept_s;
        SKID_ONE: begin
          load_out_new_s = accept_s && drain_s;
          load_skid_s    = accept_s && !drain_s;
        end
        SKID_TWO:   load_out_skid_s = drain_s;
        default:    load_out_new_s  = 1'b0;
      endcase
    end
  end

  // Output and skid data registers; output holds unless a load is steered in
  always_ff @(posedge clk) begin
    if (reset) begin
      out_fields_r  <= '0;
      out_pc_r      <= {XLEN{1'b0}};
      out_imm_r     <= {XLEN{1'b0}};
      skid_fields_r <= '0;
      skid_pc_r     <= {XLEN{1'b0}};
      skid_imm_r    <= {XLEN{1'b0}};
    end else begin
      if (load_out_new_s) begin
        out_fields_r <= dec_fields_s;
        out_pc_r     <= in_pc;
        out_imm_r    <= dec_imm_s;
      end else if (load_out_skid_s) begin
        out_fields_r <= skid_fields_r;
        out_pc_r     <= skid_pc_r;
        out_imm_r    <= skid_imm_r;
      end
      if (load_skid_s) begin
        skid_fields_r <= dec_fields_s;
        skid_pc_r     <= in_pc;
        skid_imm_r    <= dec_imm_s;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_pc      = out_pc_r;
  assign out_opcode  = out_fields_r.opcode;
  assign out_func3   = out_fields_r.func3;
  assign out_func7   = out_fields_r.func7;
  assign out_rs1     = out_fields_r.rs1;
  assign out_rs2     = out_fields_r.rs2;
  assign out_rd      = out_fields_r.rd;
  assign out_imm     = out_imm_r;
  assign out_illegal = out_fields_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three configurations share stimulus, checked against a queue model.
module tb_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [6:0]  o_opc [3];
  logic [2:0]  o_f3  [3];
  logic [6:0]  o_f7  [3];
  logic [4:0]  o_rs1 [3];
  logic [4:0]  o_rs2 [3];
  logic [4:0]  o_rd  [3];
  logic        o_ill [3];
  logic [63:0] o_pc  [3];
  logic [63:0] o_imm [3];
  logic [31:0] pc_0, imm_0, pc_1, imm_1;
  logic [63:0] pc_2, imm_2;

  int checks   = 0;
  int failures = 0;
  entry_t q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: RV32, no M
  decode_stage #(.XLEN(32), .ENABLE_M(0)) dut_rv32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_pc(pc_0), .out_opcode(o_opc[0]), .out_func3(o_f3[0]), .out_func7(o_f7[0]),
    .out_rs1(o_rs1[0]), .out_rs2(o_rs2[0]), .out_rd(o_rd[0]), .out_imm(imm_0), .out_illegal(o_ill[0]));

  // dut 1: RV32 with M
  decode_stage #(.XLEN(32), .ENABLE_M(1)) dut_rv32m (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_pc(pc_1), .out_opcode(o_opc[1]), .out_func3(o_f3[1]), .out_func7(o_f7[1]),
    .out_rs1(o_rs1[1]), .out_rs2(o_rs2[1]), .out_rd(o_rd[1]), .out_imm(imm_1), .out_illegal(o_ill[1]));

  // dut 2: RV64 with M
  decode_stage #(.XLEN(64), .ENABLE_M(1)) dut_rv64m (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .out_pc(pc_2), .out_opcode(o_opc[2]), .out_func3(o_f3[2]), .out_func7(o_f7[2]),
    .out_rs1(o_rs1[2]), .out_rs2(o_rs2[2]), .out_rd(o_rd[2]), .out_imm(imm_2), .out_illegal(o_ill[2]));

  assign o_pc[0]  = {32'h0, pc_0};
  assign o_imm[0] = {32'h0, imm_0};
  assign o_pc[1]  = {32'h0, pc_1};
  assign o_imm[1] = {32'h0, imm_1};
  assign o_pc[2]  = pc_2;
  assign o_imm[2] = imm_2;

  // Reference legality, written straight from the ISA encoding tables
  function automatic bit ref_legal(input logic [31:0] i, input bit x64, input bit m);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    if (i[1:0] != 2'b11) return 1'b0;
    case (op)
      7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (x64 && (f3 inside {3'd3, 3'd6}));
      7'h23: return (f3 <= 3'd2) || (x64 && f3 == 3'd3);
      7'h63: return !(f3 inside {3'd2, 3'd3});
      7'h67: return f3 == 3'd0;
      7'h37, 7'h17, 7'h6F: return 1'b1;
      7'h0F: return f3 == 3'd0;
      7'h73: return f3 != 3'd4;
      7'h13: begin
        if (f3 == 3'd1) return x64 ? (i[31:26] == 6'd0) : (f7 == 7'd0);
        if (f3 == 3'd5) return x64 ? (i[31:26] inside {6'h00, 6'h10}) : (f7 inside {7'h00, 7'h20});
        return 1'b1;
      end
      7'h1B: begin
        if (!x64) return 1'b0;
        if (f3 == 3'd0) return 1'b1;
        if (f3 == 3'd1) return f7 == 7'h00;
        if (f3 == 3'd5) return f7 inside {7'h00, 7'h20};
        return 1'b0;
      end
      7'h33: begin
        if (f7 == 7'h00) return 1'b1;
        if (f7 == 7'h20) return f3 inside {3'd0, 3'd5};
        if (f7 == 7'h01) return m;
        return 1'b0;
      end
      7'h3B: begin
        if (!x64) return 1'b0;
        if (f7 == 7'h00) return f3 inside {3'd0, 3'd1, 3'd5};
        if (f7 == 7'h20) return f3 inside {3'd0, 3'd5};
        if (f7 == 7'h01) return m && (f3 inside {3'd0, 3'd4, 3'd5, 3'd6, 3'd7});
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  // Reference immediate via signed arithmetic on the whole word
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input bit x64);
    longint s;
    longint r;
    s = longint'($signed(i));
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: r = s >>> 20;
      7'h23: r = ((s >>> 25) <<< 5) | longint'(i[11:7]);
      7'h63: r = ((s >>> 31) <<< 12) | (longint'(i[7]) << 11) |
                 (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
      7'h37, 7'h17: r = (s >>> 12) <<< 12;
      7'h6F: r = ((s >>> 31) <<< 20) | (longint'(i[19:12]) << 12) |
                 (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
      default: r = 0;
    endcase
    return x64 ? 64'(r) : (64'(r) & 64'h0000_0000_FFFF_FFFF);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 15))
      0:  w[6:0] = 7'h03;
      1:  w[6:0] = 7'h0F;
      2:  w[6:0] = 7'h13;
      3:  w[6:0] = 7'h17;
      4:  w[6:0] = 7'h1B;
      5:  w[6:0] = 7'h23;
      6:  w[6:0] = 7'h33;
      7:  w[6:0] = 7'h37;
      8:  w[6:0] = 7'h3B;
      9:  w[6:0] = 7'h63;
      10: w[6:0] = 7'h67;
      11: w[6:0] = 7'h6F;
      12: w[6:0] = 7'h73;
      default: w[6:0] = w[6:0];
    endcase
    case ($urandom_range(0, 3))
      0:  w[31:25] = 7'h00;
      1:  w[31:25] = 7'h20;
      2:  w[31:25] = 7'h01;
      default: w[31:25] = w[31:25];
    endcase
    return w;
  endfunction

  task automatic cmp(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Compare every DUT against the model occupancy and head-of-queue entry
  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      bit x64;
      bit m;
      bit leg;
      logic [63:0] pmask;
      x64   = (k == 2);
      m     = (k != 0);
      pmask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      cmp("in_ready", k, 64'(in_ready_w[k]), (q.size() < 2) ? 64'h1 : 64'h0);
      cmp("out_valid", k, 64'(out_valid_w[k]), (q.size() > 0) ? 64'h1 : 64'h0);
      if (q.size() > 0) begin
        leg = ref_legal(q[0].instr, x64, m);
        cmp("pc", k, o_pc[k], q[0].pc & pmask);
        cmp("opcode", k, 64'(o_opc[k]), 64'(q[0].instr[6:0]));
        cmp("func3", k, 64'(o_f3[k]), 64'(q[0].instr[14:12]));
        cmp("func7", k, 64'(o_f7[k]), 64'(q[0].instr[31:25]));
        cmp("rs1", k, 64'(o_rs1[k]), 64'(q[0].instr[19:15]));
        cmp("rs2", k, 64'(o_rs2[k]), 64'(q[0].instr[24:20]));
        cmp("rd", k, 64'(o_rd[k]), 64'(q[0].instr[11:7]));
        cmp("imm", k, o_imm[k], leg ? ref_imm(q[0].instr, x64) : 64'h0);
        cmp("illegal", k, 64'(o_ill[k]), leg ? 64'h0 : 64'h1);
      end
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check after
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                      input bit ordy, input bit fl);
    bit acc;
    bit drn;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2) && !fl;
    drn = (q.size() > 0) && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{ins, pc});
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h0050_0093; in_pc = 64'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cmp("rst_out_valid", k, 64'(out_valid_w[k]), 64'h0);
      cmp("rst_in_ready", k, 64'(in_ready_w[k]), 64'h0);
      cmp("rst_pc", k, o_pc[k], 64'h0);
      cmp("rst_imm", k, o_imm[k], 64'h0);
      cmp("rst_opcode", k, 64'(o_opc[k]), 64'h0);
      cmp("rst_illegal", k, 64'(o_ill[k]), 64'h0);
    end
    reset = 1'b0;
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // addi x1,x0,5
    step(1'b1, 32'h0050_0093, 64'h8000_0000_0000_1000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cmp("addi_opcode", k, 64'(o_opc[k]), 64'h13);
      cmp("addi_rd", k, 64'(o_rd[k]), 64'h1);
      cmp("addi_imm", k, o_imm[k], 64'h5);
      cmp("addi_illegal", k, 64'(o_ill[k]), 64'h0);
    end
    // beq x0,x0,-4
    step(1'b1, 32'hFE00_0EE3, 64'h8000_0000_0000_1004, 1'b1, 1'b0);
    cmp("beq_imm32", 0, o_imm[0], 64'h0000_0000_FFFF_FFFC);
    cmp("beq_imm64", 2, o_imm[2], 64'hFFFF_FFFF_FFFF_FFFC);
    cmp("beq_func3", 0, 64'(o_f3[0]), 64'h0);
    // all-zero word
    step(1'b1, 32'h0000_0000, 64'h8000_0000_0000_1008, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cmp("zero_illegal", k, 64'(o_ill[k]), 64'h1);
      cmp("zero_imm", k, o_imm[k], 64'h0);
    end
    // mul x0,x1,x2
    step(1'b1, 32'h0220_8033, 64'h8000_0000_0000_100C, 1'b1, 1'b0);
    cmp("mul_noM", 0, 64'(o_ill[0]), 64'h1);
    cmp("mul_M32", 1, 64'(o_ill[1]), 64'h0);
    cmp("mul_M64", 2, 64'(o_ill[2]), 64'h0);
    // lui x1,0x80000
    step(1'b1, 32'h8000_00B7, 64'h8000_0000_0000_1010, 1'b1, 1'b0);
    cmp("lui_imm64", 2, o_imm[2], 64'hFFFF_FFFF_8000_0000);
    cmp("lui_imm32", 0, o_imm[0], 64'h0000_0000_8000_0000);
    // ld x1,0(x1)
    step(1'b1, 32'h0000_B083, 64'h8000_0000_0000_1014, 1'b1, 1'b0);
    cmp("ld_rv64", 2, 64'(o_ill[2]), 64'h0);
    cmp("ld_rv32", 0, 64'(o_ill[0]), 64'h1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Back-pressure: three offers, only two fit
    step(1'b1, 32'h0050_0093, 64'h2000, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0113, 64'h2004, 1'b0, 1'b0);
    cmp("bp_in_ready_low", 0, 64'(in_ready_w[0]), 64'h0);
    step(1'b1, 32'h0050_0193, 64'h2008, 1'b0, 1'b0);
    cmp("bp_head_rd", 0, 64'(o_rd[0]), 64'h1);
    step(1'b1, 32'h0050_0193, 64'h2008, 1'b1, 1'b0);
    cmp("bp_second_rd", 0, 64'(o_rd[0]), 64'h2);
    step(1'b1, 32'h0050_0193, 64'h2008, 1'b1, 1'b0);
    cmp("bp_third_rd", 0, 64'(o_rd[0]), 64'h3);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    cmp("bp_drained", 0, 64'(out_valid_w[0]), 64'h0);

    // Flush from the full state while an instruction is offered
    step(1'b1, 32'h0050_0093, 64'h3000, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0113, 64'h3004, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0213, 64'h3008, 1'b1, 1'b1);
    cmp("flush_out_valid", 0, 64'(out_valid_w[0]), 64'h0);
    cmp("flush_in_ready", 0, 64'(in_ready_w[0]), 64'h1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    cmp("flush_no_ghost", 2, 64'(out_valid_w[2]), 64'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I/RV64I instruction decode stage sitting between the fetch stage and the register-read/execute stage. Performs full field extraction, XLEN sign-extended immediate generation and complete legality checking, including optional M-extension acceptance. A valid/ready handshake with a two-entry skid buffer lets it absorb back-pressure without a combinational ready path. A flush input supports branch redirects.

## Interface
- `XLEN`, 32: datapath width; 32 or 64. Sets immediate and PC widths and the RV64 opcodes and func3 codes that are legal.
- `ENABLE_M`, 0: 1 = OP/OP-32 with func7=0000001 is legal.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: discard all held and incoming instructions.
- `in_valid` input 1: fetch offers an instruction.
- `in_ready` output 1: stage accepts when `in_valid && in_ready`; driven directly from a register.
- `in_instr` input 32: raw instruction word.
- `in_pc` input XLEN: PC of `in_instr`.
- `out_valid` output 1: decoded entry presented.
- `out_ready` input 1: consumer takes the entry when `out_valid && out_ready`.
- `out_pc` output XLEN: PC of the presented entry.
- `out_opcode` output 7, `out_func3` output 3, `out_func7` output 7: instruction fields.
- `out_rs1` output 5, `out_rs2` output 5, `out_rd` output 5: register indices.
- `out_imm` output XLEN: sign-extended immediate for the format; 0 for R-type and illegal instructions.
- `out_illegal` output 1: instruction is not a legal encoding.

## Operation
- Decode is combinational on `in_instr`. Results are captured with `in_pc` into the output register, or into the skid register when the output register is occupied and not draining.
- Immediate formats:
  - I: LOAD, OP-IMM, OP-IMM-32, JALR.
  - S: STORE.
  - B: BRANCH, bit 0 = 0.
  - U: LUI, AUIPC; `imm[31:12]=instr[31:12]`, sign-extended above bit 31 when XLEN=64.
  - J: JAL, bit 0 = 0.
- Legal encodings; everything else sets `out_illegal=1`:
  - `instr[1:0]` must be 2'b11.
  - LOAD: func3 000, 001, 010, 100, 101; also 011 and 110 when XLEN=64.
  - STORE: func3 000, 001, 010; also 011 when XLEN=64.
  - BRANCH: func3 other than 010 and 011.
  - JALR: func3=000. LUI, AUIPC, JAL: always legal.
  - OP-IMM: slli needs func7 0000000; srli/srai need func7 0000000/0100000. For XLEN=64 only `instr[31:26]` is checked and `instr[25]` is shamt[5].
  - OP: func7 0000000 is legal; 0100000 only with func3 000 or 101; 0000001 only when ENABLE_M.
  - OP-32 and OP-IMM-32: legal only when XLEN=64, with the same rules reduced to the W subset.
  - MISC-MEM: func3=000.
  - SYSTEM: func3≠100.
- States, from (out_valid, skid_valid):
  - EMPTY: accept → ONE.
  - ONE: drain without accept → EMPTY; accept with drain → ONE with new entry; accept without drain → TWO, entry goes to skid.
  - TWO: `in_ready=0`; drain → ONE, skid moves to output.
- Ordering is strictly FIFO. No entry is dropped or duplicated.

## Timing
- Latency: an instruction accepted in cycle N is presented in cycle N+1.
- Throughput: one instruction per cycle while `out_ready=1`.
- `in_ready = !skid_valid`, registered. It is 0 in TWO and 0 while `reset` is high.
- Reset: `out_valid=0`, skid empty, all data outputs 0, `out_illegal=0`. `in_ready` rises the cycle after `reset` falls.
- `flush` has priority over every other input. Next cycle the state is EMPTY with `in_ready=1`, and any handshake in the flush cycle is ignored.
- A simultaneous accept and drain in TWO is impossible because `in_ready=0`.
- Outputs hold stable while `out_valid && !out_ready`.

## Structure
- Opcode, func3 and func7 constants (`RISCV_*`, `STORE_*`, `BRANCH_*`) belong in the shared `arch_defines.v`. Add `RISCV_OP_32` and `RISCV_OP_IMM_32` there.
- One combinational sub-module, `instr_decode #(XLEN, ENABLE_M)`: instruction in; fields, immediate and illegal flag out. It is instantiated once, before the registers.

## Test plan
- XLEN=32, push 0x00500093 (addi x1,x0,5) → next cycle `out_opcode=0x13`, `out_rd=1`, `out_imm=5`, `out_illegal=0`.
- Push 0xFE000EE3 (beq x0,x0,-4) → `out_imm=0xFFFFFFFC`, `out_func3=0`.
- Push 0x00000000 → `out_illegal=1`, `out_imm=0`. Push 0x02208033 (mul) → illegal with ENABLE_M=0, legal with ENABLE_M=1.
- Hold `out_ready=0` and offer 3 instructions → `in_ready` falls after 2 accepts. Release `out_ready` → all 3 emerge in order on consecutive cycles.
- With TWO state, assert `flush` while `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, and the offered instruction never appears.
- XLEN=64, push 0x800000B7 (lui x1,0x80000) → `out_imm=0xFFFFFFFF80000000`. Push a ld (func3 011) → legal.
